cmp_arbiter: RTL and testbench

- Shares one 4-bit compare datapath (equal / greater / less / max) among NREQ requesters.
- Round-robin arbitration picks one requester at a time. The block latches that requester's operands and op code, performs the compare, and returns a tagged, registered response.
- Sits between the switch/key input logic and the compare/display path, so several clients use one compare unit.

---
 rtl/cmp_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_cmp_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one unsigned compare unit (EQ/GT/LT/MAX) among
// NREQ requesters; answers each grant with a tagged, registered response.

module cmp_arbiter #(
  parameter int W    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ*2-1:0] req_op,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_result,
  output logic [2:0]        resp_flags
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    RESP  = 2'b10
  } state_t;

  localparam logic [NREQ-1:0] GNT_ONE = {{(NREQ-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   id_r;
  logic [W-1:0]     x_r;
  logic [W-1:0]     y_r;
  logic [1:0]       op_r;
  logic [NREQ-1:0]  gnt_r;
  logic             busy_r;
  logic             resp_valid_r;
  logic [IDW-1:0]   resp_id_r;
  logic [W-1:0]     resp_result_r;
  logic [2:0]       resp_flags_r;

  logic             found_s;
  logic [IDW-1:0]   win_s;
  logic [IDW-1:0]   idx_s;
  logic             eq_s;
  logic             gt_s;
  logic             lt_s;
  logic [W-1:0]     result_s;

  logic [W-1:0]     x_arr_s  [NREQ];
  logic [W-1:0]     y_arr_s  [NREQ];
  logic [1:0]       op_arr_s [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign x_arr_s[i]  = req_x[i*W +: W];
    assign y_arr_s[i]  = req_y[i*W +: W];
    assign op_arr_s[i] = req_op[i*2 +: 2];
  end

  // Round-robin search: first asserted request after the last winner.
  always_comb begin
    found_s = 1'b0;
    win_s   = {IDW{1'b0}};
    idx_s   = {IDW{1'b0}};
    for (int off = 1; off <= NREQ; off++) begin
      idx_s = IDW'((int'(ptr_r) + off) % NREQ);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Unsigned compare of the latched operands and op-code result select.
  always_comb begin
    eq_s     = (x_r == y_r);
    gt_s     = (x_r > y_r);
    lt_s     = (x_r < y_r);
    result_s = {W{1'b0}};
    case (op_r)
      2'b00:   result_s = {{(W-1){1'b0}}, eq_s};
      2'b01:   result_s = {{(W-1){1'b0}}, gt_s};
      2'b10:   result_s = {{(W-1){1'b0}}, lt_s};
      2'b11:   result_s = gt_s ? x_r : y_r;
      default: result_s = {W{1'b0}};
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; arbitration happens only in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (en && found_s) begin
          state_s = GRANT;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT:   state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Grant latch, response registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r         <= IDW'(NREQ - 1);
      id_r          <= {IDW{1'b0}};
      x_r           <= {W{1'b0}};
      y_r           <= {W{1'b0}};
      op_r          <= 2'b00;
      gnt_r         <= {NREQ{1'b0}};
      busy_r        <= 1'b0;
      resp_valid_r  <= 1'b0;
      resp_id_r     <= {IDW{1'b0}};
      resp_result_r <= {W{1'b0}};
      resp_flags_r  <= 3'b000;
    end else begin
      busy_r <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          resp_valid_r <= 1'b0;
          if (en && found_s) begin
            gnt_r <= GNT_ONE << win_s;
            ptr_r <= win_s;
            id_r  <= win_s;
            x_r   <= x_arr_s[win_s];
            y_r   <= y_arr_s[win_s];
            op_r  <= op_arr_s[win_s];
          end else begin
            gnt_r <= {NREQ{1'b0}};
          end
        end
        GRANT: begin
          gnt_r         <= {NREQ{1'b0}};
          resp_valid_r  <= 1'b1;
          resp_id_r     <= id_r;
          resp_result_r <= result_s;
          resp_flags_r  <= {lt_s, gt_s, eq_s};
        end
        RESP: begin
          gnt_r        <= {NREQ{1'b0}};
          resp_valid_r <= 1'b0;
        end
        default: begin
          gnt_r        <= {NREQ{1'b0}};
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt         = gnt_r;
  assign busy        = busy_r;
  assign resp_valid  = resp_valid_r;
  assign resp_id     = resp_id_r;
  assign resp_result = resp_result_r;
  assign resp_flags  = resp_flags_r;

  cmp_arbiter_chk #(.NREQ(NREQ)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .gnt        (gnt_r),
    .busy       (busy_r),
    .resp_valid (resp_valid_r)
  );

endmodule

// Protocol properties of the arbiter outputs.
module cmp_arbiter_chk #(
  parameter int NREQ = 4
) (
  input logic            clk,
  input logic            rst_n,
  input logic [NREQ-1:0] gnt,
  input logic            busy,
  input logic            resp_valid
);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_gnt_busy:   assert property (@(posedge clk) disable iff (!rst_n) (|gnt) |-> busy);
  a_resp_busy:  assert property (@(posedge clk) disable iff (!rst_n) resp_valid |-> busy);
  a_exclusive:  assert property (@(posedge clk) disable iff (!rst_n) !((|gnt) && resp_valid));

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.

module tb_cmp_arbiter;

  localparam int W    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ*2-1:0] req_op;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_result;
  logic [2:0]        resp_flags;

  int checks = 0;
  int errors = 0;

  // Reference model: cycle index of the last grant plus the pending answer.
  int             cyc  = 0;
  int             gcyc = -100;
  int             m_ptr;
  logic [NREQ-1:0] e_gnt;
  logic           e_busy;
  logic           e_valid;
  logic [IDW-1:0] e_id;
  logic [W-1:0]   e_res;
  logic [2:0]     e_flags;
  logic [IDW-1:0] p_id;
  logic [W-1:0]   p_res;
  logic [2:0]     p_flags;

  cmp_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_op      (req_op),
    .gnt         (gnt),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_flags  (resp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic model_reset();
    gcyc    = cyc - 100;
    m_ptr   = NREQ - 1;
    e_gnt   = '0;
    e_busy  = 1'b0;
    e_valid = 1'b0;
    e_id    = '0;
    e_res   = '0;
    e_flags = 3'b000;
  endtask

  // One rising edge: the model decides what the DUT must show after it.
  task automatic tick();
    int w;
    logic [W-1:0] x, y;
    logic [1:0] op;
    @(posedge clk);
    e_gnt   = '0;
    e_valid = 1'b0;
    w       = -1;
    if (cyc == gcyc + 1) begin
      e_valid = 1'b1;
      e_id    = p_id;
      e_res   = p_res;
      e_flags = p_flags;
    end else if (cyc >= gcyc + 3 && en && req != '0) begin
      for (int o = 1; o <= NREQ; o++)
        if (w < 0 && req[(m_ptr + o) % NREQ]) w = (m_ptr + o) % NREQ;
      x  = req_x[w*W +: W];
      y  = req_y[w*W +: W];
      op = req_op[w*2 +: 2];
      p_id    = IDW'(w);
      p_flags = {x < y, x > y, x == y};
      case (op)
        2'd0: p_res = (x == y) ? 4'd1 : 4'd0;
        2'd1: p_res = (x > y)  ? 4'd1 : 4'd0;
        2'd2: p_res = (x < y)  ? 4'd1 : 4'd0;
        default: p_res = (x > y) ? x : y;
      endcase
      e_gnt = 4'b0001 << w;
      m_ptr = w;
      gcyc  = cyc;
    end
    e_busy = (cyc == gcyc) || (cyc == gcyc + 1);
    cyc++;
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [1:0] op);
    req_x[i*W +: W]  = x;
    req_y[i*W +: W]  = y;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    en     = 1'b0;
    req    = '0;
    req_x  = '0;
    req_y  = '0;
    req_op = '0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req = '0; req_x = '0; req_y = '0; req_op = '0;
    #3;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", resp_id); end
    checks++; if (resp_result !== 4'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", resp_result); end
    checks++; if (resp_flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", resp_flags); end
    do_reset();
  endtask

  task automatic test_eq();
    en = 1'b1; req = 4'b0001; set_req(0, 4'd5, 4'd5, 2'b00);
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL eq_gnt: got %b expected 0001", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL eq_busy: got %b expected 1", busy); end
    req = 4'b0000;
    tick();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL eq_valid: got %b expected 1", resp_valid); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL eq_id: got %0d expected 0", resp_id); end
    checks++; if (resp_result !== 4'b0001) begin errors++; $display("FAIL eq_result: got %b expected 0001", resp_result); end
    checks++; if (resp_flags !== 3'b001) begin errors++; $display("FAIL eq_flags: got %b expected 001", resp_flags); end
    tick();
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL eq_idle: valid=%b busy=%b expected 0 0", resp_valid, busy); end
    checks++; if (resp_result !== 4'b0001) begin errors++; $display("FAIL eq_hold: got %b expected 0001", resp_result); end
  endtask

  task automatic test_max_lt();
    req = 4'b0001; set_req(0, 4'd9, 4'd3, 2'b11);
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL max_gnt: got %b expected 0001", gnt); end
    req = 4'b0000;
    tick();
    checks++; if (resp_result !== 4'b1001) begin errors++; $display("FAIL max_result: got %b expected 1001", resp_result); end
    checks++; if (resp_flags !== 3'b010) begin errors++; $display("FAIL max_flags: got %b expected 010", resp_flags); end
    tick();
    req = 4'b0001; set_req(0, 4'd9, 4'd3, 2'b10);
    tick();
    req = 4'b0000;
    tick();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL lt_valid: got %b expected 1", resp_valid); end
    checks++; if (resp_result !== 4'b0000) begin errors++; $display("FAIL lt_result: got %b expected 0000", resp_result); end
    checks++; if (resp_flags !== 3'b010) begin errors++; $display("FAIL lt_flags: got %b expected 010", resp_flags); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] eg;
    do_reset();
    en = 1'b1; req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom), 4'($urandom), 2'($urandom));
    for (int t = 0; t <= 12; t++) begin
      tick();
      eg = (t % 3 == 0) ? (4'b0001 << ((t / 3) % 4)) : 4'b0000;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt t=%0d: got %b expected %b", t, gnt, eg); end
      if (t % 3 == 1) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'((t / 3) % 4) || resp_result !== e_res) begin
          errors++;
          $display("FAIL rr_resp t=%0d: valid=%b id=%0d res=%0d expected 1 %0d %0d",
                   t, resp_valid, resp_id, resp_result, (t / 3) % 4, e_res);
        end
      end
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_enable();
    en = 1'b0; req = 4'b0100; set_req(2, 4'd1, 4'd8, 2'b01);
    repeat (5) begin
      tick();
      checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL en_low: gnt=%b busy=%b expected 0000 0", gnt, busy); end
    end
    en = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL en_gnt: got %b expected 0100", gnt); end
    en = 1'b0; req = 4'b0000;
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2) begin errors++; $display("FAIL en_drop_resp: valid=%b id=%0d expected 1 2", resp_valid, resp_id); end
    tick();
  endtask

  task automatic test_latch();
    en = 1'b1; req = 4'b0100; set_req(2, 4'd2, 4'd7, 2'b01);
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL latch_gnt: got %b expected 0100", gnt); end
    set_req(2, 4'd15, 4'd7, 2'b11); req = 4'b0000;
    tick();
    checks++; if (resp_result !== 4'b0000) begin errors++; $display("FAIL latch_result: got %b expected 0000", resp_result); end
    checks++; if (resp_flags !== 3'b100) begin errors++; $display("FAIL latch_flags: got %b expected 100", resp_flags); end
    tick();
  endtask

  task automatic test_reset_mid();
    en = 1'b1; req = 4'b0001; set_req(0, 4'd4, 4'd6, 2'b11);
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt: got %b expected 0001", gnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL mid_async: gnt=%b busy=%b expected 0000 0", gnt, busy); end
    model_reset();
    req = 4'b0010; set_req(1, 4'd3, 4'd3, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0 || resp_result !== 4'd0) begin errors++; $display("FAIL mid_noresp: valid=%b res=%0d expected 0 0", resp_valid, resp_result); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_regrant: got %b expected 0010", gnt); end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      en     = ($urandom_range(0, 7) != 0);
      req    = 4'($urandom);
      req_x  = 16'($urandom);
      req_y  = 16'($urandom);
      req_op = 8'($urandom);
      tick();
      checks++;
      if (gnt !== e_gnt || busy !== e_busy || resp_valid !== e_valid ||
          resp_id !== e_id || resp_result !== e_res || resp_flags !== e_flags) begin
        errors++;
        $display("FAIL rand n=%0d: gnt=%b busy=%b v=%b id=%0d res=%0d fl=%b expected %b %b %b %0d %0d %b",
                 n, gnt, busy, resp_valid, resp_id, resp_result, resp_flags,
                 e_gnt, e_busy, e_valid, e_id, e_res, e_flags);
      end
    end
  endtask

  initial begin
    test_reset();
    test_eq();
    test_max_lt();
    test_round_robin();
    test_enable();
    test_latch();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
